// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared data-memory/IO bus (CPU port 0, DMA/loader port 1).
// Ports: clk, rst(async low), req/we/addr/wdata per port, lock1, gnt/rdata/rvalid, stall0, bus_*.
module mem_bus_arbiter #(
  parameter int DBITS        = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [DBITS-1:0] addr0,
  input  logic [DBITS-1:0] addr1,
  input  logic [DBITS-1:0] wdata0,
  input  logic [DBITS-1:0] wdata1,
  input  logic             lock1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             stall0,
  output logic [DBITS-1:0] rdata0,
  output logic [DBITS-1:0] rdata1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [DBITS-1:0] bus_addr,
  output logic [DBITS-1:0] bus_wdata,
  output logic             bus_we,
  input  logic [DBITS-1:0] bus_rdata
);

  localparam int LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arbState;

  arbState        state;
  arbState        stateNext;
  logic [LCW-1:0] lockCnt;
  logic [LCW-1:0] lockCntNext;
  logic [SCW-1:0] starveCnt;
  logic [SCW-1:0] starveNext;
  logic           lockHold;
  logic           lockMore;
  logic           forcedRel;
  logic           starved;

  assign gnt0   = (state == OWN0);
  assign gnt1   = (state == OWN1);
  assign stall0 = req0 & ~gnt0;

  always_comb begin
    stateNext   = IDLE;
    lockCntNext = '0;
    starveNext  = '0;
    lockHold    = gnt1 & req1 & lock1;
    lockMore    = lockHold & (lockCnt < LOCK_LAST);
    forcedRel   = lockHold & ~lockMore;
    starved     = req1 & (starveCnt == STARVE_TOP);
    if (lockMore) begin
      stateNext   = OWN1;
      lockCntNext = lockCnt + 1'b1;
    end else if (forcedRel & req0) begin
      stateNext = OWN0;
    end else if (starved) begin
      stateNext = OWN1;
    end else if (req0) begin
      stateNext = OWN0;
    end else if (req1) begin
      stateNext = OWN1;
    end
    // Counter is zero for the whole grant cycle so a starved grant
    // is never repeated back-to-back over a waiting CPU.
    if (req1 && stateNext != OWN1) begin
      if (starveCnt != STARVE_TOP) starveNext = starveCnt + 1'b1;
      else starveNext = starveCnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lockCnt   <= '0;
      starveCnt <= '0;
    end else begin
      state     <= stateNext;
      lockCnt   <= lockCntNext;
      starveCnt <= starveNext;
    end
  end

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    unique case (1'b1)
      gnt0: begin
        bus_addr  = addr0;
        bus_wdata = wdata0;
        bus_we    = we0;
      end
      gnt1: begin
        bus_addr  = addr1;
        bus_wdata = wdata1;
        bus_we    = we1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0) rdata0 <= bus_rdata;
      if (gnt1 & ~we1) rdata1 <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter.
// Drives inputs 1ns after rising edges and checks there.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, stall0, rvalid0, rvalid1, bus_we;
  logic [31:0] rdata0, rdata1, bus_addr, bus_wdata, bus_rdata;
  int          passCnt = 0;
  int          totalCnt = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .DBITS(32),
    .STARVE_LIMIT(8),
    .LOCK_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req0(req0),
    .req1(req1),
    .we0(we0),
    .we1(we1),
    .addr0(addr0),
    .addr1(addr1),
    .wdata0(wdata0),
    .wdata1(wdata1),
    .lock1(lock1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .stall0(stall0),
    .rdata0(rdata0),
    .rdata1(rdata1),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we(bus_we),
    .bus_rdata(bus_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 32'h10;
    step(); step();
    totalCnt++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt0 got=%b exp=0", gnt0); else passCnt++;
    totalCnt++; if (gnt1 !== 1'b0) $display("FAIL rst_gnt1 got=%b exp=0", gnt1); else passCnt++;
    totalCnt++; if (bus_we !== 1'b0) $display("FAIL rst_bus_we got=%b exp=0", bus_we); else passCnt++;
    totalCnt++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL rst_rvalid got=%b exp=00", {rvalid0, rvalid1}); else passCnt++;
    totalCnt++; if (rdata0 !== 32'h0) $display("FAIL rst_rdata0 got=%h exp=0", rdata0); else passCnt++;
    rst = 1'b1;
    step();
    totalCnt++; if (gnt0 !== 1'b1) $display("FAIL rel_gnt0 got=%b exp=1", gnt0); else passCnt++;
    totalCnt++; if (bus_we !== 1'b1) $display("FAIL rel_bus_we got=%b exp=1", bus_we); else passCnt++;
    we0 = 1'b0; req1 = 1'b0; bus_rdata = 32'hDEAD_BEEF;
    step();
    totalCnt++; if (gnt0 !== 1'b1) $display("FAIL b2b_gnt0 got=%b exp=1", gnt0); else passCnt++;
    #2 rst = 1'b0;
    #1;
    totalCnt++; if (gnt0 !== 1'b0) $display("FAIL async_gnt0 got=%b exp=0", gnt0); else passCnt++;
    totalCnt++; if (bus_addr !== 32'h0) $display("FAIL async_addr got=%h exp=0", bus_addr); else passCnt++;
    req0 = 1'b0;
    step();
    totalCnt++; if (rvalid0 !== 1'b0) $display("FAIL inflight_rvalid0 got=%b exp=0", rvalid0); else passCnt++;
    totalCnt++; if (rdata0 !== 32'h0) $display("FAIL inflight_rdata0 got=%h exp=0", rdata0); else passCnt++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_port0_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; bus_rdata = 32'h1234;
    #1;
    totalCnt++; if (stall0 !== 1'b1) $display("FAIL p0_stall_wait got=%b exp=1", stall0); else passCnt++;
    step();
    totalCnt++; if (gnt0 !== 1'b1) $display("FAIL p0_gnt got=%b exp=1", gnt0); else passCnt++;
    totalCnt++; if (bus_addr !== 32'h40) $display("FAIL p0_addr got=%h exp=40", bus_addr); else passCnt++;
    totalCnt++; if (stall0 !== 1'b0) $display("FAIL p0_stall_gnt got=%b exp=0", stall0); else passCnt++;
    req0 = 1'b0;
    step();
    totalCnt++; if (rvalid0 !== 1'b1) $display("FAIL p0_rvalid got=%b exp=1", rvalid0); else passCnt++;
    totalCnt++; if (rdata0 !== 32'h1234) $display("FAIL p0_rdata got=%h exp=1234", rdata0); else passCnt++;
    totalCnt++; if (gnt0 !== 1'b0) $display("FAIL p0_gnt_off got=%b exp=0", gnt0); else passCnt++;
    step();
    totalCnt++; if (rvalid0 !== 1'b0) $display("FAIL p0_rvalid_pulse got=%b exp=0", rvalid0); else passCnt++;
  endtask

  task automatic test_contention();
    logic e0, e1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h100; addr1 = 32'h200; bus_rdata = 32'h5A5A;
    for (int i = 1; i <= 12; i++) begin
      step();
      e1 = (i == 9);
      e0 = ~e1;
      totalCnt++; if (gnt0 !== e0) $display("FAIL cont_gnt0 c%0d got=%b exp=%b", i, gnt0, e0); else passCnt++;
      totalCnt++; if (gnt1 !== e1) $display("FAIL cont_gnt1 c%0d got=%b exp=%b", i, gnt1, e1); else passCnt++;
      totalCnt++; if (stall0 !== e1) $display("FAIL cont_stall0 c%0d got=%b exp=%b", i, stall0, e1); else passCnt++;
      totalCnt++; if (rvalid1 !== (i == 10)) $display("FAIL cont_rvalid1 c%0d got=%b exp=%b", i, rvalid1, (i == 10)); else passCnt++;
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
  endtask

  task automatic test_lock();
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; req0 = 1'b0;
    step();
    totalCnt++; if (gnt1 !== 1'b1) $display("FAIL lock_first got=%b exp=1", gnt1); else passCnt++;
    req0 = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      totalCnt++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL lock_hold c%0d got=%b exp=01", i, {gnt0, gnt1}); else passCnt++;
    end
    step();
    totalCnt++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL lock_release got=%b exp=10", {gnt0, gnt1}); else passCnt++;
    step();
    totalCnt++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL lock_after got=%b exp=10", {gnt0, gnt1}); else passCnt++;
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    step(); step();
  endtask

  task automatic test_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'hF000_0004; wdata1 = 32'h3FF;
    #1;
    totalCnt++; if (bus_we !== 1'b0) $display("FAIL wr_we_pre got=%b exp=0", bus_we); else passCnt++;
    step();
    totalCnt++; if (gnt1 !== 1'b1) $display("FAIL wr_gnt1 got=%b exp=1", gnt1); else passCnt++;
    totalCnt++; if (bus_we !== 1'b1) $display("FAIL wr_we got=%b exp=1", bus_we); else passCnt++;
    totalCnt++; if (bus_addr !== 32'hF000_0004) $display("FAIL wr_addr got=%h exp=f0000004", bus_addr); else passCnt++;
    totalCnt++; if (bus_wdata !== 32'h3FF) $display("FAIL wr_wdata got=%h exp=3ff", bus_wdata); else passCnt++;
    req1 = 1'b0;
    step();
    totalCnt++; if (bus_we !== 1'b0) $display("FAIL wr_we_post got=%b exp=0", bus_we); else passCnt++;
    totalCnt++; if (rvalid1 !== 1'b0) $display("FAIL wr_rvalid1 got=%b exp=0", rvalid1); else passCnt++;
    we1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [3];
    data[0] = 32'hA1; data[1] = 32'hB2; data[2] = 32'hC3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step();
      totalCnt++; if (gnt1 !== 1'b1) $display("FAIL b2b_gnt1 c%0d got=%b exp=1", i, gnt1); else passCnt++;
      if (i > 0) begin
        totalCnt++; if (rdata1 !== data[i-1]) $display("FAIL b2b_rdata1 c%0d got=%h exp=%h", i, rdata1, data[i-1]); else passCnt++;
        totalCnt++; if (rvalid1 !== 1'b1) $display("FAIL b2b_rvalid1 c%0d got=%b exp=1", i, rvalid1); else passCnt++;
      end
      bus_rdata = data[i];
    end
    req1 = 1'b0;
    step();
    totalCnt++; if (rdata1 !== data[2]) $display("FAIL b2b_rdata1_last got=%h exp=%h", rdata1, data[2]); else passCnt++;
    totalCnt++; if (gnt1 !== 1'b0) $display("FAIL b2b_gnt1_off got=%b exp=0", gnt1); else passCnt++;
    step();
  endtask

  task automatic test_drop();
    req0 = 1'b1; req1 = 1'b1;
    step();
    req1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      totalCnt++; if (gnt1 !== 1'b0) $display("FAIL drop_gnt1 c%0d got=%b exp=0", i, gnt1); else passCnt++;
    end
    totalCnt++; if (dut.starveCnt !== 4'd0) $display("FAIL drop_starve got=%0d exp=0", dut.starveCnt); else passCnt++;
    req0 = 1'b0;
    step(); step();
  endtask

  task automatic test_idle();
    addr0 = 32'h1111; addr1 = 32'h2222; wdata0 = 32'h33; we0 = 1'b1; we1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      totalCnt++; if (bus_addr !== 32'h0) $display("FAIL idle_addr c%0d got=%h exp=0", i, bus_addr); else passCnt++;
      totalCnt++; if (bus_wdata !== 32'h0) $display("FAIL idle_wdata c%0d got=%h exp=0", i, bus_wdata); else passCnt++;
      totalCnt++; if (bus_we !== 1'b0) $display("FAIL idle_we c%0d got=%b exp=0", i, bus_we); else passCnt++;
      totalCnt++; if (dut.starveCnt !== 4'd0) $display("FAIL idle_starve c%0d got=%0d exp=0", i, dut.starveCnt); else passCnt++;
    end
  endtask

  initial begin
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; bus_rdata = '0;
    test_reset();
    test_port0_read();
    test_contention();
    test_lock();
    test_write();
    test_back_to_back();
    test_drop();
    test_idle();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
